gcd_stream: RTL and testbench



---
 rtl/gcd_pkg.sv | 6 +
 rtl/gcd_fifo.sv | 52 +++++
 rtl/gcd_stream.sv | 108 ++++++++++
 tb/tb_gcd_stream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD family of blocks.
package gcd_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} gcd_state_e;

endpackage

// File: rtl/gcd_fifo.sv
// First-word-fall-through operand FIFO; each entry is one {a,b} pair.
module gcd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [2*WIDTH-1:0] data_i,
  output logic [2*WIDTH-1:0] data_o,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_wr;
  logic               do_rd;

  // A full FIFO refuses a write even when a read frees a slot in the same cycle.
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign data_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/gcd_stream.sv
// Streaming GCD unit: operand FIFO feeding an iterative subtraction engine,
// results delivered in input order over a valid/ready port.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] fifo_count_o
);

  gcd_state_e         state;
  gcd_state_e         state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   res_reg;
  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   b_next;
  logic [WIDTH-1:0]   res_next;
  logic [2*WIDTH-1:0] head;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               done_calc;

  gcd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (in_valid_i),
    .rd_en  (pop),
    .data_i ({a_i, b_i}),
    .data_o (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count_o)
  );

  assign in_ready_o  = !fifo_full;
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign result_o    = res_reg;
  assign done_calc   = (a_reg == b_reg) || (a_reg == '0) || (b_reg == '0);

  always_comb begin
    state_next = state;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      CALC: begin
        if (done_calc) begin
          res_next   = (a_reg == '0) ? b_reg : a_reg;
          state_next = DONE;
        end else if (a_reg > b_reg) begin
          a_next = a_reg - b_reg;
        end else begin
          b_next = b_reg - a_reg;
        end
      end
      DONE: begin
        // Chain straight into the next pair on handshake to avoid an IDLE bubble.
        if (out_ready_i) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pop) begin
      a_next     = head[2*WIDTH-1:WIDTH];
      b_next     = head[WIDTH-1:0];
      state_next = CALC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
    end else begin
      state   <= state_next;
      a_reg   <= a_next;
      b_reg   <= b_next;
      res_reg <= res_next;
    end
  end

endmodule

// File: tb/tb_gcd_stream.sv
// Scoreboard bench for gcd_stream: random and directed pairs, Euclid reference model,
// a negedge monitor pops expected results in order.
module tb_gcd_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             busy_o;
  logic [CNT_W-1:0] fifo_count_o;

  int n_checks  = 0;
  int n_fail    = 0;
  int out_seen  = 0;
  int exp_q[$];
  bit check_bubble = 1'b0;

  always #5 clk = ~clk;

  gcd_stream #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .result_o     (result_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  function automatic int refGcd(int x, int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every accepted result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (check_bubble) begin
        checkOutput("no_idle_bubble_busy", int'(busy_o), 1);
        check_bubble = 1'b0;
      end
      if (out_valid_o && out_ready_i) begin
        out_seen++;
        if (exp_q.size() == 0) checkOutput("result_was_expected", 0, 1);
        else                   checkOutput("result_in_order", int'(result_o), exp_q.pop_front());
        check_bubble = (fifo_count_o != '0);
      end
    end
  end

  task automatic applyStimulus(input int a, input int b, input int max_cycles, output bit accepted);
    in_valid_i = 1'b1;
    a_i        = WIDTH'(a);
    b_i        = WIDTH'(b);
    accepted   = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      accepted = in_ready_o;
      if (accepted) exp_q.push_back(refGcd(a, b));
      @(posedge clk);
      #1;
      if (accepted) break;
    end
  endtask

  task automatic pushPair(input int a, input int b);
    bit acc;
    applyStimulus(a, b, 1000, acc);
    checkOutput("push_accepted", int'(acc), 1);
  endtask

  task automatic measureLatency(output int k, output bit busy_ok);
    k       = 0;
    busy_ok = 1'b1;
    while (k < 2000) begin
      @(negedge clk);
      if (out_valid_o) break;
      if (k >= 1 && !busy_o) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic waitDrain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    checkOutput("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    exp_q.delete();
    check_bubble = 1'b0;
    in_valid_i   = 1'b0;
    rst_i        = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    int  k;
    bit  busy_ok;
    bit  acc;
    int  acc_count;
    int  seen0;
    int  ra;
    int  rb;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    a_i         = '0;
    b_i         = '0;
    doReset(2);

    @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid_o), 0);
    checkOutput("reset_result", int'(result_o), 0);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_in_ready", int'(in_ready_o), 1);
    checkOutput("reset_count", int'(fifo_count_o), 0);
    @(posedge clk);
    #1;

    $display("[TB] directed (12,8)");
    pushPair(12, 8);
    in_valid_i = 1'b0;
    measureLatency(k, busy_ok);
    checkOutput("latency_12_8", k, 4);
    @(negedge clk);
    checkOutput("valid_single_cycle", int'(out_valid_o), 0);
    @(posedge clk);
    #1;

    $display("[TB] zero operands");
    pushPair(7, 0);
    in_valid_i = 1'b0;
    measureLatency(k, busy_ok);
    checkOutput("latency_7_0", k, 2);
    @(posedge clk);
    #1;
    pushPair(0, 9);
    pushPair(0, 0);
    in_valid_i = 1'b0;
    waitDrain(2000);

    $display("[TB] backpressure");
    out_ready_i = 1'b0;
    acc_count   = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus((i + 1) * 6, (i + 1) * 4, 3, acc);
      if (acc) acc_count++;
    end
    applyStimulus(250, 125, 3, acc);
    if (acc) acc_count++;
    in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("accepted_pairs", acc_count, DEPTH + 1);
    checkOutput("full_count", int'(fifo_count_o), DEPTH);
    checkOutput("full_in_ready", int'(in_ready_o), 0);
    checkOutput("held_out_valid", int'(out_valid_o), 1);
    checkOutput("held_result", int'(result_o), 2);
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    waitDrain(2000);

    $display("[TB] reset mid-calculation");
    pushPair(255, 1);
    pushPair(12, 8);
    pushPair(9, 6);
    pushPair(10, 4);
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("queued_before_reset", int'(fifo_count_o), 3);
    checkOutput("busy_before_reset", int'(busy_o), 1);
    @(posedge clk);
    #1;
    doReset(1);
    @(negedge clk);
    checkOutput("mid_reset_out_valid", int'(out_valid_o), 0);
    checkOutput("mid_reset_count", int'(fifo_count_o), 0);
    checkOutput("mid_reset_busy", int'(busy_o), 0);
    checkOutput("mid_reset_in_ready", int'(in_ready_o), 1);
    seen0 = out_seen;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("no_stale_output", out_seen - seen0, 0);

    $display("[TB] random stream");
    for (int i = 0; i < 20; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      pushPair(ra, rb);
    end
    in_valid_i = 1'b0;
    waitDrain(20000);

    $display("[TB] worst case (255,1)");
    pushPair(255, 1);
    in_valid_i = 1'b0;
    measureLatency(k, busy_ok);
    checkOutput("latency_255_1", k, 256);
    checkOutput("busy_during_worst_case", int'(busy_ok), 1);
    waitDrain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
